// File: rtl/sim_end.sv
// sim_end: end-of-test responder that sits beside the DUV.
// It tracks pass, fail and an activity watchdog, then raises a finish
// request with a status code. Simulation control acknowledges the request.
//
// Ports
//   sim_end_clk_ip         clock; all logic is on the rising edge
//   sim_end_rst_ip         synchronous active-high reset
//   sim_end_activity_ip    DUV activity strobe; restarts the watchdog
//   sim_end_pass_ip        test-pass event (pulse or level)
//   sim_end_fail_ip        test-fail event (pulse or level)
//   sim_end_wdog_limit_ip  idle-cycle limit; 0 disables the watchdog
//   sim_end_finish_ack_ip  acknowledge from simulation control (level)
//   sim_end_finish_req_op  finish request (level)
//   sim_end_status_op      00 none, 01 pass, 10 fail, 11 timeout
//   sim_end_cycles_op      cycles spent in RUN, saturating
//   sim_end_busy_op        high while in SETTLE or RUN
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | held in reset, or first cycle after release
// SETTLE | waiting SETTLE cycles; only fail is honoured
// RUN    | counting cycles and watching for end events
// REQ    | finish request high, waiting for ack
// DONE   | request dropped, results held until reset
module sim_end #(
    parameter int COUNT_W = 32,
    parameter int WDOG_W  = 16,
    parameter int SETTLE  = 4
) (
    input  logic               sim_end_clk_ip,
    input  logic               sim_end_rst_ip,
    input  logic               sim_end_activity_ip,
    input  logic               sim_end_pass_ip,
    input  logic               sim_end_fail_ip,
    input  logic [WDOG_W-1:0]  sim_end_wdog_limit_ip,
    input  logic               sim_end_finish_ack_ip,
    output logic               sim_end_finish_req_op,
    output logic [1:0]         sim_end_status_op,
    output logic [COUNT_W-1:0] sim_end_cycles_op,
    output logic               sim_end_busy_op
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_RUN    = 3'd2,
        S_REQ    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [WDOG_W-1:0]  WDOG_ONE    = WDOG_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_t             r_state;
    logic [7:0]         r_settle_cnt;
    logic [WDOG_W-1:0]  r_wdog;
    logic [COUNT_W-1:0] r_cycles;
    logic [1:0]         r_status;
    logic               r_req;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [7:0]         w_settle_nxt;
    logic [WDOG_W-1:0]  w_wdog_nxt;
    logic [COUNT_W-1:0] w_cycles_nxt;
    logic [1:0]         w_status_nxt;
    logic [WDOG_W-1:0]  w_limit_m1;
    logic               w_expire;
    logic [COUNT_W-1:0] w_cycles_sat;

    // Expiry fires when this idle cycle would be the limit-th in a row.
    // A limit lowered below the running count only matches after wrap.
    assign w_limit_m1   = sim_end_wdog_limit_ip - WDOG_ONE;
    assign w_expire     = (sim_end_wdog_limit_ip != '0) && !sim_end_activity_ip
                          && (r_wdog == w_limit_m1);
    assign w_cycles_sat = (&r_cycles) ? r_cycles : r_cycles + CNT_ONE;

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_wdog_nxt   = r_wdog;
        w_cycles_nxt = r_cycles;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                w_state_nxt  = S_SETTLE;
                w_settle_nxt = '0;
                w_wdog_nxt   = '0;
                w_cycles_nxt = '0;
                w_status_nxt = ST_NONE;
            end
            S_SETTLE: begin
                if (sim_end_fail_ip) begin
                    w_state_nxt  = S_REQ;
                    w_status_nxt = ST_FAIL;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_wdog_nxt  = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + 8'd1;
                end
            end
            S_RUN: begin
                // The cycle carrying the end event is itself counted.
                w_cycles_nxt = w_cycles_sat;
                w_wdog_nxt   = sim_end_activity_ip ? '0 : r_wdog + WDOG_ONE;
                if (sim_end_fail_ip) begin
                    w_state_nxt  = S_REQ;
                    w_status_nxt = ST_FAIL;
                end else if (sim_end_pass_ip) begin
                    w_state_nxt  = S_REQ;
                    w_status_nxt = ST_PASS;
                end else if (w_expire) begin
                    w_state_nxt  = S_REQ;
                    w_status_nxt = ST_TIMEOUT;
                end
            end
            S_REQ: begin
                if (sim_end_finish_ack_ip) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request and busy are registered from the next state so that they
    // line up with the state register without any input-to-output path.
    always_ff @(posedge sim_end_clk_ip) begin
        if (sim_end_rst_ip) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_wdog       <= '0;
            r_cycles     <= '0;
            r_status     <= ST_NONE;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_wdog       <= w_wdog_nxt;
            r_cycles     <= w_cycles_nxt;
            r_status     <= w_status_nxt;
            r_req        <= (w_state_nxt == S_REQ);
            r_busy       <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RUN);
        end
    end

    assign sim_end_finish_req_op = r_req;
    assign sim_end_status_op     = r_status;
    assign sim_end_cycles_op     = r_cycles;
    assign sim_end_busy_op       = r_busy;

endmodule

// File: tb/tb_sim_end.sv
module tb_sim_end;

    localparam int SETTLE_N = 4;
    localparam int SAT_W    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        act;
    logic        pass_i;
    logic        fail_i;
    logic [15:0] limit;
    logic        ack;

    logic        req_a, busy_a;
    logic [1:0]  status_a;
    logic [31:0] cycles_a;
    logic        req_b, busy_b;
    logic [1:0]  status_b;
    logic [SAT_W-1:0] cycles_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sim_end #(.COUNT_W(32), .WDOG_W(16), .SETTLE(SETTLE_N)) u_main (
        .sim_end_clk_ip        (clk),
        .sim_end_rst_ip        (rst),
        .sim_end_activity_ip   (act),
        .sim_end_pass_ip       (pass_i),
        .sim_end_fail_ip       (fail_i),
        .sim_end_wdog_limit_ip (limit),
        .sim_end_finish_ack_ip (ack),
        .sim_end_finish_req_op (req_a),
        .sim_end_status_op     (status_a),
        .sim_end_cycles_op     (cycles_a),
        .sim_end_busy_op       (busy_a)
    );

    sim_end #(.COUNT_W(SAT_W), .WDOG_W(16), .SETTLE(SETTLE_N)) u_sat (
        .sim_end_clk_ip        (clk),
        .sim_end_rst_ip        (rst),
        .sim_end_activity_ip   (act),
        .sim_end_pass_ip       (pass_i),
        .sim_end_fail_ip       (fail_i),
        .sim_end_wdog_limit_ip (limit),
        .sim_end_finish_ack_ip (ack),
        .sim_end_finish_req_op (req_b),
        .sim_end_status_op     (status_b),
        .sim_end_cycles_op     (cycles_b),
        .sim_end_busy_op       (busy_b)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_SETTLE = 1, P_RUN = 2, P_REQ = 3, P_DONE = 4;
    int m_phase   = P_IDLE;
    int m_settled = 0;
    int m_run     = 0;
    int m_idle    = 0;
    int m_status  = 0;
    bit m_valid   = 1'b0;

    task automatic model_step();
        bit expired;
        if (rst) begin
            m_phase = P_IDLE; m_settled = 0; m_run = 0; m_idle = 0; m_status = 0;
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                P_IDLE: begin m_phase = P_SETTLE; m_settled = 0; end
                P_SETTLE: begin
                    if (fail_i) begin m_status = 2; m_phase = P_REQ; end
                    else begin
                        m_settled++;
                        if (m_settled == SETTLE_N) begin m_phase = P_RUN; m_idle = 0; end
                    end
                end
                P_RUN: begin
                    m_run++;
                    expired = (limit != 0) && !act && (m_idle == int'(limit) - 1);
                    if (fail_i)       m_status = 2;
                    else if (pass_i)  m_status = 1;
                    else if (expired) m_status = 3;
                    if (fail_i || pass_i || expired) m_phase = P_REQ;
                    m_idle = act ? 0 : (m_idle + 1) % 65536;
                end
                P_REQ: if (ack) m_phase = P_DONE;
                default: ;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_valid) begin
                chk("req",      req_a,    (m_phase == P_REQ));
                chk("busy",     busy_a,   (m_phase == P_SETTLE || m_phase == P_RUN));
                chk("status",   status_a, m_status);
                chk("cycles",   cycles_a, m_run);
                chk("sat_req",  req_b,    (m_phase == P_REQ));
                chk("sat_stat", status_b, m_status);
                chk("sat_cyc",  cycles_b, (m_run > 15) ? 15 : m_run);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic a, input logic p, input logic f, input logic k);
        @(negedge clk);
        rst = r; act = a; pass_i = p; fail_i = f; ack = k;
    endtask

    task automatic idle_n(input int n, input logic k);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, k);
    endtask

    // Five cycles of reset, then release; the next drive is RUN cycle 1.
    task automatic reset_seq(input logic k);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, k);
        for (int i = 0; i < 1 + SETTLE_N; i++) drive(0, 0, 0, 0, k);
    endtask

    initial begin
        rst = 1; act = 0; pass_i = 0; fail_i = 0; ack = 0; limit = 16'd0;

        // Reset values
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("rst_req", req_a, 0); chk("rst_status", status_a, 0);
        chk("rst_cycles", cycles_a, 0); chk("rst_busy", busy_a, 0);

        // Basic pass in RUN cycle 10, ack 3 cycles later
        reset_seq(0);
        chk("run_busy", busy_a, 1);
        idle_n(9, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("pass_req", req_a, 1); chk("pass_status", status_a, 1);
        chk("pass_cycles", cycles_a, 10); chk("pass_busy", busy_a, 0);
        idle_n(2, 0);
        chk("pass_req_hold", req_a, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("ack_req", req_a, 0); chk("ack_status", status_a, 1);
        chk("ack_cycles", cycles_a, 10);
        idle_n(2, 0);

        // Fail priority over pass in RUN cycle 3
        reset_seq(0);
        idle_n(2, 0);
        drive(0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("prio_status", status_a, 2); chk("prio_cycles", cycles_a, 3);

        // Pass ignored in SETTLE cycle 1, fail in SETTLE cycle 2
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("sp_req", req_a, 0); chk("sp_busy", busy_a, 1); chk("sp_status", status_a, 0);
        drive(0, 0, 0, 0, 0);
        chk("sf_req", req_a, 1); chk("sf_status", status_a, 2); chk("sf_cycles", cycles_a, 0);

        // Watchdog: limit 8, activity at 1, 5, 12 -> timeout in cycle 20
        limit = 16'd8;
        reset_seq(0);
        for (int k = 1; k <= 20; k++) begin
            drive(0, (k == 1 || k == 5 || k == 12), 0, 0, 0);
            if (k == 20) chk("wd_early", req_a, 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("wd_req", req_a, 1); chk("wd_status", status_a, 3); chk("wd_cycles", cycles_a, 20);

        // Activity exactly in the expiry cycle (9) suppresses the timeout
        reset_seq(0);
        for (int k = 1; k <= 17; k++) begin
            drive(0, (k == 1 || k == 9), 0, 0, 0);
            if (k == 11) chk("wd_save", req_a, 0);
        end
        drive(0, 0, 0, 0, 0);
        chk("wd2_status", status_a, 3); chk("wd2_cycles", cycles_a, 17);
        limit = 16'd0;

        // Ack held from reset: ignored until REQ, then DONE one cycle later
        reset_seq(1);
        chk("ackh_busy", busy_a, 1);
        idle_n(2, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("ackh_req", req_a, 1); chk("ackh_status", status_a, 1);
        drive(0, 0, 0, 0, 1);
        chk("ackh_done", req_a, 0);
        drive(0, 1, 0, 1, 1);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("done_req", req_a, 0); chk("done_status", status_a, 1);
        chk("done_cycles", cycles_a, 3); chk("done_busy", busy_a, 0);

        // Reset while in REQ, then a fresh run
        reset_seq(0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("mid_req_hi", req_a, 1);
        drive(1, 0, 0, 0, 0);
        chk("mid_req", req_a, 0); chk("mid_status", status_a, 0);
        chk("mid_cycles", cycles_a, 0); chk("mid_busy", busy_a, 0);
        for (int i = 0; i < 1 + SETTLE_N; i++) drive(0, 0, 0, 0, 0);
        chk("mid_settle_cyc", cycles_a, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("mid_new_cycles", cycles_a, 1); chk("mid_new_status", status_a, 1);

        // Saturation on the 4-bit instance
        reset_seq(0);
        idle_n(20, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("sat_cycles", cycles_b, 15); chk("sat_status", status_b, 1);
        chk("wide_cycles", cycles_a, 21);

        // Randomized traffic checked by the model
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) limit = 16'($urandom_range(0, 20));
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 3) == 0));
            if (m_phase == P_DONE && $urandom_range(0, 7) == 0) rst = 1'b1;
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
